// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Purpose : shared widths, constants, fetch FSM encoding and the modular
//           address-increment helper used by the instruction fetch stage.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam addr_t RESET_VECTOR = 14'h0000;
  localparam data_t NOP_WORD     = 32'h0000_0000;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // Word-address increment; wraps silently at 2^ADDR_WIDTH.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Purpose : bundles the fetch stage's control inputs, program-memory port and
//           IF/ID-facing outputs.
// Signals : stall, branch_valid, branch_target   (hazard unit / execute)
//           pmem_addr, pmem_data                  (sync-read program memory)
//           instruction_out, instruction_valid_out,
//           return_addr_out, take_branch_addr_out (to IF/ID register)
// Modports: master = fetch stage, slave = surrounding datapath / memory.
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic  stall;
  logic  branch_valid;
  addr_t branch_target;
  addr_t pmem_addr;
  data_t pmem_data;
  data_t instruction_out;
  logic  instruction_valid_out;
  addr_t return_addr_out;
  logic  take_branch_addr_out;

  modport master (
    input  stall, branch_valid, branch_target, pmem_data,
    output pmem_addr, instruction_out, instruction_valid_out,
           return_addr_out, take_branch_addr_out
  );

  modport slave (
    output stall, branch_valid, branch_target, pmem_data,
    input  pmem_addr, instruction_out, instruction_valid_out,
           return_addr_out, take_branch_addr_out
  );

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// -----------------------------------------------------------------------------
// instruction_fetch_program_counter
// Purpose : program counter register with load / increment / hold.
//           Load has priority over increment; neither means hold.
// Ports   : i_clock, i_nreset (async active-low) ; i_load, i_load_value ;
//           i_inc ; o_pc (current value).
// -----------------------------------------------------------------------------
module instruction_fetch_program_counter
  import instruction_fetch_pkg::*;
(
  input  logic  i_clock,
  input  logic  i_nreset,
  input  logic  i_load,
  input  addr_t i_load_value,
  input  logic  i_inc,
  output addr_t o_pc
);

  addr_t r_pc;

  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      r_pc <= RESET_VECTOR;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (i_inc) begin
      r_pc <= addr_inc(r_pc);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Purpose : IF stage. Owns the PC, issues addresses to a synchronous-read
//           program memory and presents the returned word, its return address
//           and a first-word-at-branch-target flag to the IF/ID register.
// Ports   : i_clock   - system clock, rising edge
//           i_nreset  - asynchronous active-low reset
//           bus       - instruction_fetch_if.master (control, memory, IF/ID)
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_nreset,
  instruction_fetch_if.master   bus
);

  fetch_state_e r_state, w_state_next;
  addr_t        r_fetch_pc, w_fetch_pc_next;   // address of word on pmem_data
  logic         r_data_valid, w_data_valid_next;
  logic         r_redirected, w_redirected_next;

  logic  w_pc_load;
  logic  w_pc_inc;
  addr_t w_pc_load_value;
  addr_t w_pc;
  addr_t w_pmem_addr;
  logic  w_present;

  instruction_fetch_program_counter u_pc (
    .i_clock      (i_clock),
    .i_nreset     (i_nreset),
    .i_load       (w_pc_load),
    .i_load_value (w_pc_load_value),
    .i_inc        (w_pc_inc),
    .o_pc         (w_pc)
  );

  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state      <= FETCH_BOOT;
      r_fetch_pc   <= RESET_VECTOR;
      r_data_valid <= 1'b0;
      r_redirected <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_data_valid <= w_data_valid_next;
      r_redirected <= w_redirected_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_fetch_pc_next   = r_fetch_pc;
    w_data_valid_next = r_data_valid;
    w_redirected_next = r_redirected;
    w_pc_load         = 1'b0;
    w_pc_inc          = 1'b0;
    w_pc_load_value   = addr_inc(bus.branch_target);
    w_pmem_addr       = w_pc;

    case (r_state)
      FETCH_BOOT: begin
        // Control inputs are ignored until the reset-vector read is in flight.
        w_pmem_addr       = RESET_VECTOR;
        w_state_next      = FETCH_RUN;
        w_fetch_pc_next   = RESET_VECTOR;
        w_pc_load         = 1'b1;
        w_pc_load_value   = addr_inc(RESET_VECTOR);
        w_data_valid_next = 1'b1;
        w_redirected_next = 1'b0;
      end
      FETCH_RUN: begin
        if (bus.branch_valid) begin
          // Redirect wins over stall: issue the target straight to memory.
          w_pmem_addr       = bus.branch_target;
          w_fetch_pc_next   = bus.branch_target;
          w_pc_load         = 1'b1;
          w_data_valid_next = 1'b1;
          w_redirected_next = 1'b1;
        end else if (bus.stall) begin
          // Re-read the word being presented so pmem_data stays unchanged.
          w_pmem_addr = r_fetch_pc;
        end else begin
          w_pmem_addr       = w_pc;
          w_fetch_pc_next   = w_pc;
          w_pc_inc          = 1'b1;
          w_redirected_next = 1'b0;
        end
      end
      default: begin
        w_state_next = FETCH_BOOT;
      end
    endcase
  end

  // The word in flight during a redirect is the wrong-path word: squash it.
  assign w_present = r_data_valid && !bus.branch_valid;

  assign bus.pmem_addr             = w_pmem_addr;
  assign bus.instruction_out       = w_present ? bus.pmem_data : NOP_WORD;
  assign bus.instruction_valid_out = w_present;
  assign bus.return_addr_out       = addr_inc(r_fetch_pc);
  assign bus.take_branch_addr_out  = r_redirected && r_data_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench: directed scenarios followed by randomized
// stall / branch / reset traffic compared against a reference model that
// tracks only the address currently presented to IF/ID.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if bus();

  instruction_fetch dut (
    .i_clock  (clk),
    .i_nreset (nreset),
    .bus      (bus)
  );

  // Program memory contents: 32'hA000_0000 | address
  function automatic data_t mem_word(input addr_t a);
    return 32'hA000_0000 | {18'b0, a};
  endfunction

  initial bus.pmem_data = '0;
  always @(posedge clk) bus.pmem_data <= mem_word(bus.pmem_addr);

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: which word address is presented this cycle, whether it
  // is real, whether it is the first word after a redirect, and whether the
  // stage is still waiting for its boot fetch.
  bit    m_booting;
  addr_t m_addr;
  bit    m_valid;
  bit    m_landing;

  // Snapshot of the last step's observed outputs for directed checks.
  data_t s_instr;
  logic  s_valid;
  logic  s_tb;
  addr_t s_ret;
  addr_t s_pmem;

  task automatic model_reset();
    m_booting = 1'b1;
    m_addr    = RESET_VECTOR;
    m_valid   = 1'b0;
    m_landing = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, check, advance one clock.
  task automatic step(input logic s, input logic bv, input addr_t bt);
    data_t e_instr;
    logic  e_valid;
    addr_t e_ret;
    addr_t e_pmem;
    logic  e_tb;
    bus.stall         = s;
    bus.branch_valid  = bv;
    bus.branch_target = bt;
    #1;
    e_valid = m_valid && !bv;
    e_instr = e_valid ? mem_word(m_addr) : NOP_WORD;
    e_ret   = m_addr + addr_t'(1);
    e_tb    = m_landing && m_valid;
    if (m_booting)  e_pmem = RESET_VECTOR;
    else if (bv)    e_pmem = bt;
    else if (s)     e_pmem = m_addr;
    else            e_pmem = m_addr + addr_t'(1);
    s_instr = bus.instruction_out;
    s_valid = bus.instruction_valid_out;
    s_tb    = bus.take_branch_addr_out;
    s_ret   = bus.return_addr_out;
    s_pmem  = bus.pmem_addr;
    check_eq("pmem_addr", 32'(s_pmem), 32'(e_pmem));
    check_eq("instruction_out", s_instr, e_instr);
    check_eq("instruction_valid", 32'(s_valid), 32'(e_valid));
    check_eq("return_addr", 32'(s_ret), 32'(e_ret));
    check_eq("take_branch_addr", 32'(s_tb), 32'(e_tb));
    $display("t=%0t stall=%0b bv=%0b tgt=%h | pmem=%h instr=%h v=%0b ret=%h tb=%0b",
             $time, s, bv, bt, s_pmem, s_instr, s_valid, s_ret, s_tb);
    @(posedge clk);
    if (m_booting) begin
      m_booting = 1'b0;
      m_addr    = RESET_VECTOR;
      m_valid   = 1'b1;
      m_landing = 1'b0;
    end else if (bv) begin
      m_addr    = bt;
      m_landing = 1'b1;
    end else if (!s) begin
      m_addr    = m_addr + addr_t'(1);
      m_landing = 1'b0;
    end
    @(negedge clk);
  endtask

  // Called at a falling edge: assert reset, check async reset values, hold.
  task automatic reset_pulse(input int hold_cycles);
    nreset            = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    #1;
    check_eq("rst_instruction_out", bus.instruction_out, NOP_WORD);
    check_eq("rst_instruction_valid", 32'(bus.instruction_valid_out), 32'd0);
    check_eq("rst_take_branch_addr", 32'(bus.take_branch_addr_out), 32'd0);
    check_eq("rst_return_addr", 32'(bus.return_addr_out), 32'h0000_0001);
    check_eq("rst_pmem_addr", 32'(bus.pmem_addr), 32'h0000_0000);
    $display("t=%0t reset asserted for %0d cycles", $time, hold_cycles);
    model_reset();
    repeat (hold_cycles) @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    logic  r_s, r_bv;
    addr_t r_bt;
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    model_reset();
    @(negedge clk);
    reset_pulse(2);

    // Boot and sequential fetch
    step(1'b0, 1'b0, '0);
    check_eq("boot_valid", 32'(s_valid), 32'd0);
    step(1'b0, 1'b0, '0);
    check_eq("first_word", s_instr, 32'hA000_0000);
    check_eq("first_ret", 32'(s_ret), 32'h1);
    step(1'b0, 1'b0, '0);
    check_eq("second_word", s_instr, 32'hA000_0001);
    step(1'b0, 1'b0, '0);
    check_eq("third_word", s_instr, 32'hA000_0002);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Branch while presenting 0x0005
    step(1'b0, 1'b1, 14'h0100);
    check_eq("br_squash_valid", 32'(s_valid), 32'd0);
    step(1'b0, 1'b0, '0);
    check_eq("br_target_word", s_instr, 32'hA000_0100);
    check_eq("br_flag", 32'(s_tb), 32'd1);
    check_eq("br_ret", 32'(s_ret), 32'h101);
    step(1'b0, 1'b0, '0);
    check_eq("br_flag_clear", 32'(s_tb), 32'd0);

    // Three-cycle stall while presenting 0x0010
    step(1'b0, 1'b1, 14'h0010);
    repeat (3) begin
      step(1'b1, 1'b0, '0);
      check_eq("stall_word", s_instr, 32'hA000_0010);
      check_eq("stall_pmem", 32'(s_pmem), 32'h10);
      check_eq("stall_ret", 32'(s_ret), 32'h11);
    end
    step(1'b0, 1'b0, '0);
    check_eq("unstall_word", s_instr, 32'hA000_0010);
    check_eq("unstall_pmem", 32'(s_pmem), 32'h11);
    step(1'b0, 1'b0, '0);
    check_eq("after_stall_word", s_instr, 32'hA000_0011);

    // Branch and stall in the same cycle
    step(1'b1, 1'b1, 14'h0200);
    check_eq("br_stall_pmem", 32'(s_pmem), 32'h200);
    step(1'b0, 1'b0, '0);
    check_eq("br_stall_word", s_instr, 32'hA000_0200);

    // Wrap at the top of the address space
    step(1'b0, 1'b1, 14'h3FFF);
    step(1'b0, 1'b0, '0);
    check_eq("wrap_word", s_instr, 32'hA000_3FFF);
    check_eq("wrap_ret", 32'(s_ret), 32'h0);
    step(1'b0, 1'b0, '0);
    check_eq("wrap_next_word", s_instr, 32'hA000_0000);

    // Reset mid-run while presenting 0x0042
    step(1'b0, 1'b1, 14'h0042);
    step(1'b0, 1'b0, '0);
    check_eq("pre_reset_word", s_instr, 32'hA000_0042);
    reset_pulse(1);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check_eq("restart_word", s_instr, 32'hA000_0000);

    // Randomized traffic
    repeat (400) begin
      if ($urandom_range(0, 99) < 2) begin
        reset_pulse(int'($urandom_range(1, 3)));
      end else begin
        r_s  = ($urandom_range(0, 99) < 25);
        r_bv = ($urandom_range(0, 99) < 15);
        if ($urandom_range(0, 3) == 0) r_bt = 14'h3FFF - addr_t'($urandom_range(0, 2));
        else                           r_bt = addr_t'($urandom);
        step(r_s, r_bv, r_bt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
